// File: rtl/var_module.sv
// var_module: LayerNorm variance stage, var = E[x^2] - mean^2 with zero clamp,
// accumulating LANES squares per cycle and handing var/mean downstream.
module var_module #(
    parameter int NUM_ELEM  = 64,
    parameter int LOG2_ELEM = 6,
    parameter int LANES     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*NUM_ELEM-1:0]   a_in,
    input  logic [15:0]              mean_in,
    input  logic [31:0]              mean_sq_in,
    output logic [31:0]              var_out,
    output logic [15:0]              mean_out,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int STEPS = NUM_ELEM / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int AW    = 32 + LOG2_ELEM;

    typedef enum logic [1:0] {IDLE, ACCUM, FIN, OUT} state_t;

    state_t                 state_q, state_d;
    logic [16*NUM_ELEM-1:0] row_q, row_d;
    logic [AW-1:0]          acc_q, acc_d, lane_sum;
    logic [CW-1:0]          k_q, k_d;
    logic [15:0]            mean_q, mean_d, mean_out_q, mean_out_d;
    logic [31:0]            msq_q, msq_d, var_q, var_d, ex2;
    logic                   fire_in, fire_out, last;

    function automatic logic [31:0] square(input logic signed [15:0] x);
        logic signed [31:0] xe;
        xe = x;
        return xe * xe;
    endfunction

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready;
    assign last      = k_q == CW'(STEPS - 1);
    assign ex2       = 32'(acc_q >> LOG2_ELEM);
    assign var_out   = var_q;
    assign mean_out  = mean_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            mean_q     <= '0;
            msq_q      <= '0;
            var_q      <= '0;
            mean_out_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            mean_q     <= mean_d;
            msq_q      <= msq_d;
            var_q      <= var_d;
            mean_out_q <= mean_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fire_in  ? ACCUM : IDLE;
            ACCUM:   state_d = last     ? FIN   : ACCUM;
            FIN:     state_d = OUT;
            default: state_d = fire_out ? IDLE  : OUT;
        endcase
    end

    // The row shifts down each ACCUM cycle so the lanes always read the low slices.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + AW'(square(row_q[l*16 +: 16]));
    end

    always_comb begin
        row_d      = row_q;
        acc_d      = acc_q;
        k_d        = k_q;
        mean_d     = mean_q;
        msq_d      = msq_q;
        var_d      = var_q;
        mean_out_d = mean_out_q;
        if (fire_in) begin
            row_d  = a_in;
            mean_d = mean_in;
            msq_d  = mean_sq_in;
            acc_d  = '0;
            k_d    = '0;
        end
        if (state_q == ACCUM) begin
            row_d = row_q >> (16 * LANES);
            acc_d = acc_q + lane_sum;
            k_d   = k_q + 1'b1;
        end
        if (state_q == FIN) begin
            var_d      = (ex2 >= msq_q) ? ex2 - msq_q : '0;
            mean_out_d = mean_q;
        end
    end
endmodule

// File: tb/tb_var_module.sv
// tb_var_module: directed vectors with hand-computed variance results for var_module.
module tb_var_module;
    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [1023:0] a_in = '0;
    logic [15:0]   mean_in = '0;
    logic [31:0]   mean_sq_in = '0;
    logic [31:0]   var_out;
    logic [15:0]   mean_out;
    logic          out_valid;
    logic          out_ready = 1;
    int            n_checks = 0;
    int            n_fail = 0;

    var_module dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .mean_in(mean_in), .mean_sq_in(mean_sq_in),
        .var_out(var_out), .mean_out(mean_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] alt(input logic [15:0] a, input logic [15:0] b);
        logic [1023:0] r;
        for (int i = 0; i < 64; i++) r[i*16 +: 16] = (i % 2 == 1) ? b : a;
        return r;
    endfunction

    function automatic logic [1023:0] one(input int idx, input logic [15:0] v);
        logic [1023:0] r;
        r = '0;
        r[idx*16 +: 16] = v;
        return r;
    endfunction

    // Presents a row one cycle, then checks result timing and values at T0+9.
    task automatic run_row(input string tag, input logic [1023:0] row, input logic [15:0] m,
                           input logic [31:0] msq, input logic [31:0] ev, input logic [15:0] em);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a_in = row; mean_in = m; mean_sq_in = msq; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a_in = '1; mean_in = 16'hDEAD; mean_sq_in = 32'h0;
        repeat (8) @(posedge clk);
        #1;
        check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".var"}, var_out, ev);
        check({tag, ".mean"}, 32'(mean_out), 32'(em));
    endtask

    task automatic drain(input string tag);
        out_ready = 1;
        @(posedge clk); #1;
        check({tag, ".drop"}, 32'(out_valid), 32'd0);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.var", var_out, 32'd0);
        check("rst.mean", 32'(mean_out), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        run_row("zero", '0, 16'h0000, 32'h0, 32'h0, 16'h0000); drain("zero");
        run_row("ones", alt(16'h0100, 16'h0100), 16'h0100, 32'h00010000, 32'h0, 16'h0100); drain("ones");
        run_row("pm1", alt(16'h0100, 16'hFF00), 16'h0000, 32'h0, 32'h00010000, 16'h0000); drain("pm1");
        run_row("min", alt(16'h8000, 16'h8000), 16'h8000, 32'h40000000, 32'h0, 16'h8000); drain("min");
        run_row("clamp", alt(16'h8000, 16'h8000), 16'h8000, 32'h50000000, 32'h0, 16'h8000); drain("clamp");
        run_row("twos", alt(16'h0200, 16'h0200), 16'h0100, 32'h00010000, 32'h00030000, 16'h0100); drain("twos");
        run_row("floor1", one(0, 16'h0008), 16'h0000, 32'h0, 32'h1, 16'h0000); drain("floor1");
        run_row("floor0", one(0, 16'h0007), 16'h0000, 32'h0, 32'h0, 16'h0000); drain("floor0");
        run_row("last", one(63, 16'hFF00), 16'h0004, 32'h0, 32'h00000400, 16'h0004); drain("last");

        out_ready = 0;
        run_row("hold", alt(16'h0100, 16'hFF00), 16'h0123, 32'h0, 32'h00010000, 16'h0123);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold.valid", 32'(out_valid), 32'd1);
            check("hold.var", var_out, 32'h00010000);
            check("hold.mean", 32'(mean_out), 32'h0123);
            check("hold.in_ready", 32'(in_ready), 32'd0);
        end
        drain("hold");

        a_in = alt(16'h0100, 16'hFF00); mean_in = 16'h0055; mean_sq_in = 32'h0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.var", var_out, 32'd0);
        check("arst.mean", 32'(mean_out), 32'd0);
        @(posedge clk); #1 rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("arst.no_pulse", 32'(seen), 32'd0);
        run_row("post", alt(16'h0100, 16'hFF00), 16'h0000, 32'h0, 32'h00010000, 16'h0000); drain("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
